// File: rtl/memory_copy_engine.sv
// memory_copy_engine: DMA-style initiator that copies (or, with DMA_FILL_EN,
// fills) blocks of 32-bit words over the phoeniX data memory interface.
// Ports: clk, reset (async active-low), start/source_address/destination_address/
//   word_count request, fill_mode/fill_value (DMA_FILL_EN only), busy/done/error
//   status, data_memory_interface_{enable,state,address,frame_mask,data} bus.
module memory_copy_engine #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            source_address,
  input  logic [31:0]            destination_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
`ifdef DMA_FILL_EN
  input  logic                   fill_mode,
  input  logic [31:0]            fill_value,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   data_memory_interface_enable,
  output logic                   data_memory_interface_state,
  output logic [31:0]            data_memory_interface_address,
  output logic [3:0]             data_memory_interface_frame_mask,
  inout  wire  [31:0]            data_memory_interface_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [31:0]            buf_q, buf_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   fill_q, fill_d;

  logic                   fill_req;
  logic [31:0]            fill_word;
  logic                   misaligned;

`ifdef DMA_FILL_EN
  assign fill_req  = fill_mode;
  assign fill_word = fill_value;
`else
  assign fill_req  = 1'b0;
  assign fill_word = 32'h0;
`endif

  assign misaligned = (|source_address[1:0])
                    | (|destination_address[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else if (word_count == '0) begin
            state_d = FINISH;
          end else begin
            src_d  = source_address;
            dst_d  = destination_address;
            cnt_d  = word_count;
            fill_d = fill_req;
            // Fill reuses the write buffer as the constant source.
            if (fill_req) buf_d = fill_word;
            state_d = fill_req ? WRITE : READ;
          end
        end
      end
      READ: begin
        buf_d   = data_memory_interface_data;
        state_d = WRITE;
      end
      WRITE: begin
        src_d = src_q + 32'd4;
        dst_d = dst_q + 32'd4;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == COUNT_WIDTH'(1)) state_d = FINISH;
        else state_d = fill_q ? WRITE : READ;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == READ) || (state_q == WRITE);
  assign done  = (state_q == FINISH);
  assign error = err_q;

  assign data_memory_interface_enable     = busy;
  assign data_memory_interface_state      = (state_q == WRITE);
  assign data_memory_interface_frame_mask = busy ? 4'b1111 : 4'b0000;

  always_comb begin
    data_memory_interface_address = 32'h0;
    if (state_q == READ)  data_memory_interface_address = src_q;
    if (state_q == WRITE) data_memory_interface_address = dst_q;
  end

  // Reset forces IDLE asynchronously, which releases the bus at once.
  assign data_memory_interface_data = (state_q == WRITE) ? buf_q : 'z;

endmodule

// File: tb/tb_memory_copy_engine.sv
// tb_memory_copy_engine: randomized scoreboard bench for memory_copy_engine.
// Responder memory plus word-level reference model of copy/fill transfers.
module tb_memory_copy_engine;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_a = '0;
  logic [31:0]   dst_a = '0;
  logic [CW-1:0] wc = '0;
`ifdef DMA_FILL_EN
  logic          fill_mode = 1'b0;
  logic [31:0]   fill_value = '0;
`endif
  logic          busy, done, error;
  logic          en, st;
  logic [31:0]   addr;
  logic [3:0]    mask;
  wire  [31:0]   bus;

  logic          rd_act = 1'b0;
  logic [31:0]   rd_data = '0;

  assign bus = (rd_act && en && !st) ? rd_data : 'z;

  memory_copy_engine #(.COUNT_WIDTH(CW)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .start                            (start),
    .source_address                   (src_a),
    .destination_address              (dst_a),
    .word_count                       (wc),
`ifdef DMA_FILL_EN
    .fill_mode                        (fill_mode),
    .fill_value                       (fill_value),
`endif
    .busy                             (busy),
    .done                             (done),
    .error                            (error),
    .data_memory_interface_enable     (en),
    .data_memory_interface_state      (st),
    .data_memory_interface_address    (addr),
    .data_memory_interface_frame_mask (mask),
    .data_memory_interface_data       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        expq[$];
  txn_t        mon_e;
  logic [31:0] mon_d;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          tests = 0;
  int          fails = 0;

  // Responder + bus monitor: sample request at negedge, answer reads,
  // commit writes, and check each transaction against the scoreboard.
  always @(negedge clk) begin
    if (en) begin
      if (!st) begin
        rd_data = mem.exists(addr) ? mem[addr] : 32'h0;
        rd_act  = 1'b1;
        mon_d   = rd_data;
      end else begin
        rd_act    = 1'b0;
        mem[addr] = bus;
        mon_d     = bus;
      end
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL bus_unexpected got wr=%0d addr=%h data=%h, required no transaction",
                 st, addr, mon_d);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.wr !== st || mon_e.a !== addr || mon_e.d !== mon_d
            || mask !== 4'hF) begin
          fails++;
          $display("FAIL bus_txn got wr=%0d addr=%h data=%h mask=%h, required wr=%0d addr=%h data=%h mask=f",
                   st, addr, mon_d, mask, mon_e.wr, mon_e.a, mon_e.d);
        end
      end
    end else begin
      rd_act = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] s, input int n);
    logic [31:0] a, v;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      if (!ref_mem.exists(a)) begin
        v = $urandom;
        ref_mem[a] = v;
        mem[a] = v;
      end
    end
  endtask

  // Word-by-word copy: each word is read then written, in address order.
  task automatic expect_copy(input logic [31:0] s, input logic [31:0] d,
                             input int n);
    logic [31:0] sa, da, v;
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      v  = rd_ref(sa);
      expq.push_back({1'b0, sa, v});
      expq.push_back({1'b1, da, v});
      ref_mem[da] = v;
    end
  endtask

  task automatic expect_fill(input logic [31:0] d, input int n,
                             input logic [31:0] fv);
    logic [31:0] da;
    for (int i = 0; i < n; i++) begin
      da = d + 32'(4 * i);
      expq.push_back({1'b1, da, fv});
      ref_mem[da] = fv;
    end
  endtask

  task automatic run(input string nm, input logic [31:0] s,
                     input logic [31:0] d, input int n, input bit fill,
                     input logic [31:0] fv, input bit junk);
    bit mis;
    int ed, lim;
    logic [2:0] got, exp;
    mis = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    if (mis) ed = 0;
    else if (n == 0) ed = 1;
    else if (fill) ed = n + 1;
    else ed = 2 * n + 1;
    lim = mis ? 3 : ed + 2;
    if (!mis && n > 0) begin
      if (fill) expect_fill(d, n, fv);
      else begin
        preload(s, n);
        expect_copy(s, d, n);
      end
    end
    @(negedge clk);
    src_a = s;
    dst_a = d;
    wc    = CW'(n);
`ifdef DMA_FILL_EN
    fill_mode  = fill;
    fill_value = fv;
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= lim; j++) begin
      @(negedge clk);
      got = {done, busy, error};
      exp = {ed != 0 && j == ed,
             !mis && n > 0 && j < ed,
             mis && j == 1};
      chk($sformatf("%s_status_c%0d", nm, j), 64'(got), 64'(exp));
      // Stray starts while the engine is active must be ignored.
      if (junk && j <= ed && ed > 1 && $urandom_range(0, 2) == 0) begin
        src_a = $urandom;
        dst_a = $urandom & 32'hFFFF_FFFC;
        wc    = CW'($urandom_range(1, 5));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_queue_empty"}, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] s, d;
    int n, bad;
    bit f;
    #3;
    chk("reset_outputs", {en, st, addr, mask, busy, done, error},
        {1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h100 + 32'(4 * i)] = 32'hA0A0_0000 + 32'(i);
      mem[32'h100 + 32'(4 * i)]     = 32'hA0A0_0000 + 32'(i);
    end
    run("copy4", 32'h100, 32'h200, 4, 1'b0, 32'h0, 1'b0);
    run("zero_len", 32'h100, 32'h240, 0, 1'b0, 32'h0, 1'b0);
    run("misaligned", 32'h102, 32'h600, 4, 1'b0, 32'h0, 1'b0);
    chk("misaligned_mem", 64'(mem.exists(32'h600)), 64'd0);
    run("wrap", 32'hFFFF_FFFC, 32'h500, 2, 1'b0, 32'h0, 1'b0);

    // Abort during the 3rd write: bus sequence equals the first 3 words.
    preload(32'h3000, 8);
    expect_copy(32'h3000, 32'h3800, 3);
    @(negedge clk);
    src_a = 32'h3000;
    dst_a = 32'h3800;
    wc    = CW'(8);
`ifdef DMA_FILL_EN
    fill_mode = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_in_write3", {en, st}, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("abort_release", {en, st, addr, mask, busy},
        {1'b0, 1'b0, 32'h0, 4'h0, 1'b0});
    chk("abort_queue", 64'(expq.size()), 64'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || en) bad++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || en) bad++;
    end
    chk("abort_no_done", 64'(bad), 64'd0);
    run("after_reset", 32'h3100, 32'h3900, 3, 1'b0, 32'h0, 1'b1);

`ifdef DMA_FILL_EN
    run("fill3", 32'h0, 32'h300, 3, 1'b1, 32'hDEAD_BEEF, 1'b1);
    run("fill_mis", 32'h1, 32'h340, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      s = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      d = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) s = s | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d = d | 32'($urandom_range(1, 3));
      f = 1'b0;
`ifdef DMA_FILL_EN
      f = ($urandom_range(0, 3) == 0);
`endif
      run($sformatf("rand%0d", i), s, d, n, f, $urandom, 1'b1);
    end

    bad = 0;
    foreach (ref_mem[k]) begin
      if (!mem.exists(k) || mem[k] !== ref_mem[k]) bad++;
    end
    chk("final_memory", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
